// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake. Results are held until the next division completes.
module seq_restoring_divider #(
  parameter int unsigned DW = 6,
  parameter int unsigned VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [DW-1:0] dvd_q;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] dvs_q;
  logic [VW:0]   prem_q, prem_d, prem_shift;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, dbz_q;
  logic [DW-1:0] quotient_q;
  logic [VW-1:0] remainder_q;
  logic          qbit;

  // The partial remainder is always < divisor before the shift, so its top
  // bit is zero and dropping it loses nothing.
  always_comb begin
    prem_shift = {prem_q[VW-1:0], dvd_q[DW-1]};
    qbit       = 1'b0;
    prem_d     = prem_shift;
    if (prem_shift >= {1'b0, dvs_q}) begin
      prem_d = prem_shift - {1'b0, dvs_q};
      qbit   = 1'b1;
    end
    quo_d = {quo_q[DW-2:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            quo_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= CW'(DW - 1);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          prem_q <= prem_d;
          dvd_q  <= {dvd_q[DW-2:0], 1'b0};
          quo_q  <= quo_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // Divide by zero runs the full sequence; only the result is overridden.
            if (dvs_q == '0) begin
              quotient_q  <= '1;
              remainder_q <= '0;
              dbz_q       <= 1'b1;
            end else begin
              quotient_q  <= quo_d;
              remainder_q <= prem_d[VW-1:0];
              dbz_q       <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
